// File: rtl/wf_completion_tracker.sv
// Wavefront completion tracker: per-WF in-flight counters, halt tracking and a
// round-robin valid/ready slot that offers finished wavefronts back to fetch.
module wf_completion_tracker #(
  parameter int NUM_WF       = 40,
  parameter int WF_ID_W      = 6,
  parameter int NUM_RET      = 3,
  parameter int CNT_W        = 4,
  parameter int MAX_INFLIGHT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       decode_valid,
  input  logic                       decode_halt,
  input  logic [WF_ID_W-1:0]         decode_wfid,
  input  logic                       issue_valid,
  input  logic [WF_ID_W-1:0]         issue_wfid,
  input  logic [NUM_RET-1:0]         retire_valid,
  input  logic [NUM_RET*WF_ID_W-1:0] retire_wfid,
  input  logic                       kill_en,
  input  logic [WF_ID_W-1:0]         kill_wfid,
  input  logic [NUM_WF-1:0]          mem_wait,
  output logic                       done_valid,
  output logic [WF_ID_W-1:0]         done_wfid,
  input  logic                       done_ready,
  output logic [NUM_WF-1:0]          no_inflight,
  output logic [NUM_WF-1:0]          max_inflight,
  output logic                       cnt_err
);

  localparam int SUM_W = CNT_W + 2;

  logic [CNT_W-1:0]   cnt     [NUM_WF];
  logic [CNT_W-1:0]   cnt_nxt [NUM_WF];
  logic [NUM_WF-1:0]  halted, halted_nxt, ovf_nxt, cand;
  logic [WF_ID_W-1:0] rr_ptr, winner, rr_nxt;
  logic               found, accept, slot_free, kill_done;

  // Clamp a signed counter result into [0, MAX_INFLIGHT]; MSB flags a clamp.
  function automatic logic [CNT_W:0] clamp_cnt(input logic signed [SUM_W-1:0] v);
    if (v < 0)
      return {1'b1, {CNT_W{1'b0}}};
    if (v > $signed(SUM_W'(MAX_INFLIGHT)))
      return {1'b1, CNT_W'(MAX_INFLIGHT)};
    return {1'b0, v[CNT_W-1:0]};
  endfunction

  assign accept    = done_valid && done_ready;
  assign slot_free = !done_valid || done_ready;
  assign kill_done = done_valid && kill_en && (kill_wfid == done_wfid);

  always_comb begin
    logic signed [SUM_W-1:0] sum;
    logic [CNT_W:0]          res;
    logic                    kill_hit;
    sum        = '0;
    res        = '0;
    kill_hit   = 1'b0;
    ovf_nxt    = '0;
    halted_nxt = halted;
    cand       = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      kill_hit = kill_en && (kill_wfid == WF_ID_W'(i));
      sum = $signed({2'b00, cnt[i]});
      if (issue_valid && issue_wfid == WF_ID_W'(i))
        sum = sum + $signed(SUM_W'(1));
      for (int k = 0; k < NUM_RET; k++)
        if (retire_valid[k] && retire_wfid[k*WF_ID_W +: WF_ID_W] == WF_ID_W'(i))
          sum = sum - $signed(SUM_W'(1));
      res = clamp_cnt(sum);
      // Kill wins over any same-cycle traffic, so it never raises an error.
      cnt_nxt[i] = kill_hit ? '0 : res[CNT_W-1:0];
      ovf_nxt[i] = !kill_hit && res[CNT_W];

      if (decode_valid && decode_halt && decode_wfid == WF_ID_W'(i))
        halted_nxt[i] = 1'b1;
      if ((accept && done_wfid == WF_ID_W'(i)) || kill_hit)
        halted_nxt[i] = 1'b0;

      cand[i] = halted[i] && (cnt[i] == '0) && !mem_wait[i] && !kill_hit &&
                !(done_valid && done_wfid == WF_ID_W'(i));
    end
  end

  // Round-robin pick starting at rr_ptr.
  always_comb begin
    int                 idx_i;
    logic [WF_ID_W-1:0] idx;
    idx_i  = 0;
    idx    = '0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_WF; k++) begin
      idx_i = int'(rr_ptr) + k;
      if (idx_i >= NUM_WF)
        idx_i = idx_i - NUM_WF;
      idx = WF_ID_W'(idx_i);
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    rr_nxt = (winner == WF_ID_W'(NUM_WF - 1)) ? '0 : winner + WF_ID_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WF; i++)
        cnt[i] <= '0;
      halted     <= '0;
      done_valid <= 1'b0;
      done_wfid  <= '0;
      rr_ptr     <= '0;
      cnt_err    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WF; i++)
        cnt[i] <= cnt_nxt[i];
      halted  <= halted_nxt;
      cnt_err <= cnt_err | (|ovf_nxt);
      if (slot_free && found) begin
        done_valid <= 1'b1;
        done_wfid  <= winner;
        rr_ptr     <= rr_nxt;
      end else if (accept || kill_done) begin
        done_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_WF; i++) begin
      no_inflight[i]  = (cnt[i] == '0);
      max_inflight[i] = (cnt[i] >= CNT_W'(MAX_INFLIGHT));
    end
  end

endmodule

// File: doc/wf_completion_tracker.md
WF_COMPLETION_TRACKER -- requirements
Module: wf_completion_tracker

Interface
REQ-001 SHALL provide parameters, one per line:
  NUM_WF, 40, wavefront slots tracked
  WF_ID_W, 6, wavefront id width (2^WF_ID_W >= NUM_WF)
  NUM_RET, 3, retire channels (SGPR, VGPR, branch, ...)
  CNT_W, 4, per-WF in-flight counter width
  MAX_INFLIGHT, 15, in-flight ceiling (<= 2^CNT_W-1)
REQ-002 SHALL have one clock; reset is asynchronous and active-low; ports, one per line:
  clk  in  1  clock, all state on rising edge
  rst  in  1  asynchronous active-low reset
  decode_valid  in  1  decoded instruction valid
  decode_halt  in  1  decoded instruction is s_endpgm/halt
  decode_wfid  in  WF_ID_W  wavefront of decoded instruction
  issue_valid  in  1  instruction issued to an ALU
  issue_wfid  in  WF_ID_W  wavefront of issued instruction
  retire_valid  in  NUM_RET  per-channel retire strobe
  retire_wfid  in  NUM_RET*WF_ID_W  packed retire ids, channel k at [k*WF_ID_W +: WF_ID_W]
  kill_en  in  1  abort wavefront
  kill_wfid  in  WF_ID_W  wavefront to abort
  mem_wait  in  NUM_WF  outstanding memory op per WF
  done_valid  out  1  finished wavefront offered to fetch
  done_wfid  out  WF_ID_W  finished wavefront id
  done_ready  in  1  fetch accepts done_wfid
  no_inflight  out  NUM_WF  counter == 0
  max_inflight  out  NUM_WF  counter >= MAX_INFLIGHT
  cnt_err  out  1  sticky counter over/underflow
REQ-003 SHALL ignore any id >= NUM_WF on every input port (no state change).

Function
REQ-004 Per-WF counter SHALL update each cycle: cnt' = cnt + issue_hit - (number of retire channels hitting that WF), all hits counted in the same cycle.
REQ-005 Arithmetic SHALL be done at CNT_W+2 bits; result < 0 SHALL clamp to 0 and set cnt_err; result > MAX_INFLIGHT SHALL clamp to MAX_INFLIGHT and set cnt_err.
REQ-006 Simultaneous issue and one retire to the same WF SHALL leave cnt unchanged, with no error.
REQ-007 no_inflight and max_inflight SHALL be decoded from registered counters (no input-to-output combinational path).
REQ-008 decode_valid & decode_halt SHALL set halted[decode_wfid] at the next edge; decode_valid without halt SHALL not modify halted.
REQ-009 candidate[i] = halted[i] & (cnt[i]==0) & ~mem_wait[i] & ~(done_valid & done_wfid==i).
REQ-010 Output stage SHALL be a registered valid/ready slot: when empty (or accepted this cycle) and any candidate exists, it SHALL load the winner at the next edge.
REQ-011 Arbitration SHALL be round-robin: search starts at rr_ptr, wraps NUM_WF-1 -> 0; on load rr_ptr <- winner+1 (wrap to 0 at NUM_WF).
REQ-012 done_valid and done_wfid SHALL hold stable until done_valid & done_ready.
REQ-013 On done_valid & done_ready, halted[done_wfid] SHALL clear at that edge; a back-to-back load of a different candidate at the same edge SHALL be allowed (one done per cycle throughput).
REQ-014 Halt-to-done latency SHALL be 2 cycles minimum: halt decoded in cycle N, halted=1 in N+1, done_valid=1 in N+2 (counter 0, mem_wait 0).
REQ-015 kill_en SHALL clear halted[kill_wfid] and cnt[kill_wfid] to 0 at the next edge, overriding same-cycle halt, issue and retire to that WF.
REQ-016 If kill_wfid equals a held done_wfid, done_valid SHALL drop at the next edge unless accepted in the same cycle.
REQ-017 A halt for a WF whose halted bit is already set SHALL have no additional effect (no duplicate done).

Reset
REQ-018 While rst=0: all counters 0, halted all 0, done_valid 0, done_wfid 0, rr_ptr 0, cnt_err 0; no_inflight all 1, max_inflight all 0.
REQ-019 Reset asserted mid-handshake SHALL drop done_valid immediately (asynchronously); no done is replayed after release.
REQ-020 First state update SHALL occur on the first rising edge after rst returns to 1.

Verification
REQ-021 Halt wf 5, cnt 0, mem_wait 0, ready=1 -> done_valid=1, done_wfid=5 two cycles after halt, one cycle wide; halted[5]=0 after.
REQ-022 Issue wf 3 x3, halt wf 3, then retire wf 3 on channels 0 and 2 same cycle, then channel 1 -> no done until cnt reaches 0; done_wfid=3 two cycles after last retire; cnt_err=0.
REQ-023 Halt wfs 2, 7, 39 same window, ready=1 -> dones in order 2, 7, 39; with rr_ptr=8 start -> 39, 2, 7.
REQ-024 done_valid held with ready=0 for 10 cycles -> done_wfid stable; on ready=1 clear, next candidate presented next cycle.
REQ-025 Retire wf 4 with cnt 0 -> cnt stays 0, cnt_err=1 sticky; issue wf 4 x16 with MAX_INFLIGHT=15 -> max_inflight[4]=1, cnt=15.
REQ-026 Kill wf 9 while done_wfid=9 and ready=0 -> done_valid=0 next cycle, halted[9]=0, cnt[9]=0; async reset mid-operation -> all outputs at REQ-018 values.
